// File: rtl/dm_access_unit.sv
// dm_access_unit -- data-memory access stage behind the control unit.
//
// Takes a load or store from the single-cycle core. It drives one request on a
// req/gnt/rvalid memory bus, returns sign- or zero-extended load data, and
// holds the core stalled until the access completes.
//
// Optional feature: define DM_MISALIGN_TRAP_EN to trap misaligned H/W accesses.
// A trapped access never reaches the bus and produces a one-cycle err pulse.
// Without the macro, H ignores addr[0], W ignores addr[1:0], and err is raised
// only on timeout.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   req_valid, DmWr       access present this cycle; 1=store, 0=load
//   DmCtrl                000 B, 001 H, 010 W, 100 BU, 101 HU, others W
//   addr, wdata           byte address from ALU, store data (rs2)
//   stall                 hold PC/instruction while 1
//   rdata, rdata_valid    extended load result and its 1-cycle RESP pulse
//   err                   1-cycle RESP pulse on timeout or trapped misalign
//   mem_req/we/addr/be/wdata  bus request fields (word address, lane-replicated data)
//   mem_gnt, mem_rvalid, mem_rdata  bus handshake and read data
module dm_access_unit #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        DmWr,
  input  logic [2:0]  DmCtrl,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic          we_q;
  logic [2:0]    ctrl_q;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic          err_q;
  logic [CW-1:0] cnt;

  logic          tmo, abort, ld_cap, misalign;
  logic          is_b, is_h;
  logic [31:0]   ld_ext;
  logic [7:0]    ld_byte;
  logic [15:0]    ld_half;

  // Size decode on the captured access: ctrl[1:0] selects the width and
  // ctrl[2] marks the unsigned variant. Any unlisted code falls through to W.
  assign is_b = (ctrl_q[1:0] == 2'b00);
  assign is_h = (ctrl_q[1:0] == 2'b01);

`ifdef DM_MISALIGN_TRAP_EN
  logic in_b, in_h;
  assign in_b     = (DmCtrl[1:0] == 2'b00);
  assign in_h     = (DmCtrl[1:0] == 2'b01);
  assign misalign = (in_h & addr[0]) | (!in_b & !in_h & (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // The access is aborted in its TIMEOUT-th cycle spent in REQ or WAIT.
  assign tmo = (cnt == CW'(TIMEOUT - 1));

  // Load lane select and extension.
  always_comb begin
    ld_byte = mem_rdata[8*addr_q[1:0] +: 8];
    ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    if (is_b)      ld_ext = {{24{ld_byte[7]  & ~ctrl_q[2]}}, ld_byte};
    else if (is_h) ld_ext = {{16{ld_half[15] & ~ctrl_q[2]}}, ld_half};
    else           ld_ext = mem_rdata;
  end

  always_comb begin
    state_nxt = state;
    abort     = 1'b0;
    ld_cap    = 1'b0;
    case (state)
      IDLE: if (req_valid) state_nxt = misalign ? RESP : REQ;
      REQ: begin
        // A store finishes on its grant. Otherwise the timeout wins over
        // a load grant that arrives in the very last budget cycle.
        if (mem_gnt && we_q)  state_nxt = RESP;
        else if (tmo)         begin state_nxt = RESP; abort = 1'b1; end
        else if (mem_gnt)     state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_rvalid)       begin state_nxt = RESP; ld_cap = 1'b1; end
        else if (tmo)         begin state_nxt = RESP; abort = 1'b1; end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      ctrl_q  <= 3'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      rdata_q <= 32'b0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= DmWr;
          ctrl_q  <= DmCtrl;
          addr_q  <= addr;
          wdata_q <= wdata;
          rdata_q <= 32'b0;
          err_q   <= misalign;
          cnt     <= '0;
        end
        REQ, WAIT: begin
          cnt <= cnt + 1'b1;
          if (abort) begin
            err_q   <= 1'b1;
            rdata_q <= 32'b0;
          end
          if (ld_cap) rdata_q <= ld_ext;
        end
        default: ;
      endcase
    end
  end

  // stall is combinational so the core holds in the capture cycle itself.
  // It is gated by rst because req_valid may be high during reset.
  assign stall       = !rst & ((state == IDLE && req_valid) || state == REQ || state == WAIT);
  assign rdata       = rdata_q;
  assign rdata_valid = (state == RESP) & !we_q;
  assign err         = (state == RESP) & err_q;

  assign mem_req   = (state == REQ);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  always_comb begin
    if (!mem_req)  mem_be = 4'b0000;
    else if (is_b) mem_be = 4'b0001 << addr_q[1:0];
    else if (is_h) mem_be = addr_q[1] ? 4'b1100 : 4'b0011;
    else           mem_be = 4'b1111;
  end
  always_comb begin
    if (is_b)      mem_wdata = {4{wdata_q[7:0]}};
    else if (is_h) mem_wdata = {2{wdata_q[15:0]}};
    else           mem_wdata = wdata_q;
  end
endmodule
